// File: rtl/io_bus_sel.sv
// Master-side IO bus select controller: decodes the master address into a one-hot slave select,
// strobes the slave for WAIT_STATES+1 cycles and returns its read byte. Optional: IO_BUS_SEL_RANGE_CHECK_EN.
module io_bus_sel #(
    parameter int NR_OF_BUSSES_OUT = 4,
    parameter int ADDR_W           = 6,
    parameter int SLAVE_ADDR_W     = 4,
    parameter int WAIT_STATES      = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_W-1:0]               m_addr,
    input  logic                            m_wr,
    input  logic                            m_rd,
    input  logic [7:0]                      m_data_in,
    output logic [7:0]                      m_data_out,
    output logic                            m_ack,
    output logic                            m_err,
    output logic [NR_OF_BUSSES_OUT-1:0]     s_sel,
    output logic [SLAVE_ADDR_W-1:0]         s_addr,
    output logic                            s_wr,
    output logic                            s_rd,
    output logic [7:0]                      s_data_out,
    input  logic [NR_OF_BUSSES_OUT*8-1:0]   s_data_in
);

    localparam int IDX_W = ADDR_W - SLAVE_ADDR_W;
    localparam int NB    = NR_OF_BUSSES_OUT;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    state_t                  state_reg, state_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic                    is_wr_reg, is_wr_next;
    logic [3:0]              wait_reg, wait_next;
    logic [NB-1:0]           sel_reg, sel_next;
    logic [SLAVE_ADDR_W-1:0] s_addr_reg, s_addr_next;
    logic [7:0]              s_dout_reg, s_dout_next;
    logic                    s_wr_reg, s_wr_next;
    logic                    s_rd_reg, s_rd_next;
    logic                    ack_reg, ack_next;
    logic [7:0]              mdata_reg, mdata_next;
`ifdef IO_BUS_SEL_RANGE_CHECK_EN
    logic                    err_reg, err_next;
`endif

    logic [IDX_W-1:0] req_idx;
    logic [NB-1:0]    req_hit;
    logic [NB-1:0]    lat_hit;
    logic [7:0]       rd_slice [NB];
    logic [7:0]       rd_mux;

    assign req_idx = m_addr[ADDR_W-1:SLAVE_ADDR_W];

    // Per-slave decode; an index beyond the last slave matches no bit.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_dec
            localparam logic [31:0] K = 32'(gi);
            assign req_hit[gi]  = (32'(req_idx) == K);
            assign lat_hit[gi]  = (32'(idx_reg) == K);
            assign rd_slice[gi] = lat_hit[gi] ? s_data_in[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    always_comb begin
        rd_mux = 8'h00;
        for (int k = 0; k < NB; k++) begin
            rd_mux = rd_mux | rd_slice[k];
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        is_wr_next  = is_wr_reg;
        wait_next   = wait_reg;
        sel_next    = '0;
        s_addr_next = s_addr_reg;
        s_dout_next = s_dout_reg;
        s_wr_next   = 1'b0;
        s_rd_next   = 1'b0;
        ack_next    = 1'b0;
        mdata_next  = mdata_reg;
`ifdef IO_BUS_SEL_RANGE_CHECK_EN
        err_next    = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (m_wr || m_rd) begin
`ifdef IO_BUS_SEL_RANGE_CHECK_EN
                    if (!(|req_hit)) begin
                        state_next = ERR;
                        ack_next   = 1'b1;
                        err_next   = 1'b1;
                        mdata_next = 8'hFF;
                    end else
`endif
                    begin
                        state_next  = ACCESS;
                        idx_next    = req_idx;
                        is_wr_next  = m_wr;
                        wait_next   = 4'(WAIT_STATES);
                        sel_next    = req_hit;
                        s_addr_next = m_addr[SLAVE_ADDR_W-1:0];
                        s_dout_next = m_data_in;
                        // Write wins when both strobes are raised together.
                        s_wr_next   = m_wr;
                        s_rd_next   = m_rd & ~m_wr;
                    end
                end
            end
            ACCESS: begin
                if (wait_reg == 4'd0) begin
                    state_next = DONE;
                    ack_next   = 1'b1;
                    if (!is_wr_reg) begin
                        mdata_next = rd_mux;
                    end
                end else begin
                    wait_next = wait_reg - 4'd1;
                    sel_next  = sel_reg;
                    s_wr_next = s_wr_reg;
                    s_rd_next = s_rd_reg;
                end
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            is_wr_reg  <= 1'b0;
            wait_reg   <= 4'd0;
            sel_reg    <= '0;
            s_addr_reg <= '0;
            s_dout_reg <= 8'h00;
            s_wr_reg   <= 1'b0;
            s_rd_reg   <= 1'b0;
            ack_reg    <= 1'b0;
            mdata_reg  <= 8'h00;
`ifdef IO_BUS_SEL_RANGE_CHECK_EN
            err_reg    <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            is_wr_reg  <= is_wr_next;
            wait_reg   <= wait_next;
            sel_reg    <= sel_next;
            s_addr_reg <= s_addr_next;
            s_dout_reg <= s_dout_next;
            s_wr_reg   <= s_wr_next;
            s_rd_reg   <= s_rd_next;
            ack_reg    <= ack_next;
            mdata_reg  <= mdata_next;
`ifdef IO_BUS_SEL_RANGE_CHECK_EN
            err_reg    <= err_next;
`endif
        end
    end

    assign m_data_out = mdata_reg;
    assign m_ack      = ack_reg;
    assign s_sel      = sel_reg;
    assign s_addr     = s_addr_reg;
    assign s_wr       = s_wr_reg;
    assign s_rd       = s_rd_reg;
    assign s_data_out = s_dout_reg;
`ifdef IO_BUS_SEL_RANGE_CHECK_EN
    assign m_err      = err_reg;
`else
    assign m_err      = 1'b0;
`endif

endmodule

// File: doc/io_bus_sel.md
# io_bus_sel

Master-side IO bus select controller: the counterpart of the slave read-bus combiner. It takes a single-master IO access (address, write/read strobe, write data) and decodes the upper address bits into a one-hot slave select. It drives registered write/read strobes to the selected slave for a programmable number of wait states and returns the selected slave's read byte with a one-cycle acknowledge. It sits between the CPU IO port and the array of IO peripherals.

## Interface
- NR_OF_BUSSES_OUT, 4, number of slave buses (1..16)
- ADDR_W, 6, master IO address width
- SLAVE_ADDR_W, 4, per-slave local address width; slave index = m_addr[ADDR_W-1:SLAVE_ADDR_W]
- WAIT_STATES, 1, extra strobe cycles per access (0..15)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- m_addr  input  ADDR_W  master IO address
- m_wr  input  1  write request
- m_rd  input  1  read request
- m_data_in  input  8  master write data
- m_data_out  output  8  read data, valid with m_ack, held until next read completes
- m_ack  output  1  one-cycle access-complete pulse
- m_err  output  1  one-cycle out-of-range pulse (with m_ack), only with range check compiled in
- s_sel  output  NR_OF_BUSSES_OUT  one-hot slave select
- s_addr  output  SLAVE_ADDR_W  local address to slaves
- s_wr  output  1  write strobe
- s_rd  output  1  read strobe
- s_data_out  output  8  write data to slaves
- s_data_in  input  NR_OF_BUSSES_OUT*8  slave read buses, slave k at bits [k*8+7:k*8]

## Operation
- All outputs are registered. Reset value of every output: 0 (m_data_out = 8'h00).
- FSM states: IDLE, ACCESS, DONE, ERR.
- IDLE: if m_wr or m_rd sampled high, latch address, data, direction; m_wr and m_rd both high -> write, read ignored. Index < NR_OF_BUSSES_OUT -> ACCESS; otherwise see Configuration.
- ACCESS: s_sel one-hot on index, s_addr = latched low bits, s_data_out = latched data, s_wr or s_rd high; wait counter runs WAIT_STATES+1 cycles, then -> DONE. Read data captured from slice index of s_data_in on the final ACCESS cycle (selection, not OR: non-selected slices ignored).
- DONE: s_sel/s_wr/s_rd low, m_ack high one cycle, m_data_out updated on reads only; -> IDLE.
- ERR: m_ack and m_err high one cycle, m_data_out = 8'hFF, no slave strobe; -> IDLE.
- Requests in ACCESS, DONE, ERR are ignored; master holds strobes low until m_ack.
- Reset low at any cycle: next edge FSM to IDLE, pending access discarded, all outputs 0, no ack.

## Timing
- Request sampled at edge E0; s_sel/strobes high from after E0 through E(WAIT_STATES+1), i.e. WAIT_STATES+1 cycles.
- Read data sampled at E(WAIT_STATES+1); m_ack high from E(WAIT_STATES+1) to E(WAIT_STATES+2).
- Earliest next request sampled at E(WAIT_STATES+3); back-to-back period WAIT_STATES+3 cycles.
- Out-of-range with check: m_ack/m_err high from E0 to E1; next request at E2.

## Configuration
- IO_BUS_SEL_RANGE_CHECK_EN defined: index >= NR_OF_BUSSES_OUT goes to ERR (m_err, data 8'hFF, no strobe).
- Not defined: m_err tied 0; out-of-range index runs a normal timed ACCESS with s_sel = 0 (s_wr/s_rd still pulse), ack at normal latency, read data 8'h00.

## Test plan
- N=4, W=1: write 6'h25 data 8'hA5 -> s_sel=4'b0100, s_addr=4'h5, s_data_out=8'hA5, s_wr high 2 cycles, m_ack 3rd cycle after E0.
- Read 6'h3C, slave 3 drives 8'h5A, others 8'h00 -> s_rd 2 cycles, m_ack with m_data_out=8'h5A.
- Read 6'h11, slave 0 drives 8'hFF, slave 1 drives 8'h12 -> m_data_out=8'h12.
- N=3, read 6'h30: macro on -> m_ack+m_err one cycle after E0, m_data_out=8'hFF, s_sel=0; macro off -> m_ack at normal latency, m_data_out=8'h00, m_err=0.
- rst low during ACCESS -> next cycle s_sel=0, s_wr=s_rd=0, m_data_out=0, no m_ack.
- m_wr=m_rd=1 to 6'h02 data 8'h3C -> s_wr pulses, s_rd stays 0, m_data_out unchanged.
